fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, default 7, SHALL set the program counter and instruction memory address width (128 words).
REQ-002 Parameter DATA_W, default 16, SHALL set the instruction width.
REQ-003 Parameter ROM_INIT, default "inst_rom.mif", SHALL name the instruction memory initialisation file.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clock  in  1  system clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 pc_clr  in  1  program counter clear request.
REQ-008 pc_up  in  1  program counter increment request.
REQ-009 ld  in  1  fetch request: load the instruction register from memory at the current PC.
REQ-010 instruction  out  DATA_W  instruction register contents, held stable between fetches.
REQ-011 pc_o  out  PC_W  current program counter value.
REQ-012 ir_valid  out  1  one-cycle pulse in the first cycle a newly fetched instruction is visible.
REQ-013 busy  out  1  high while a fetch is in progress.
REQ-014 ld_err  out  1  sticky flag: ld was received while busy.

Function
REQ-015 The PC SHALL be a PC_W-bit register: pc_clr sets it to 0; otherwise pc_up increments it modulo 2^PC_W (127 wraps to 0).
REQ-016 When pc_clr and pc_up are both high, pc_clr SHALL take priority.
REQ-017 The fetch FSM SHALL have exactly three states: F_IDLE, F_READ and F_CAPTURE.
REQ-018 In F_IDLE, a sampled ld SHALL latch fetch_addr <= pc (the pre-update value, even if pc_up or pc_clr is high in the same cycle) and move the FSM to F_READ.
REQ-019 In F_READ, the memory address SHALL be fetch_addr; the memory registers its output on the exiting edge; next state is F_CAPTURE.
REQ-020 In F_CAPTURE, instruction <= memory data and ir_valid <= 1 SHALL occur on the exiting edge; next state is F_IDLE.
REQ-021 Latency SHALL be fixed: with ld sampled at edge N, the new instruction and ir_valid=1 appear in cycle N+3; ir_valid is high for exactly that one cycle.
REQ-022 busy SHALL be high in F_READ and F_CAPTURE, and low in F_IDLE.
REQ-023 ld sampled while busy SHALL be ignored (no restart, no second fetch) and SHALL set ld_err, which stays set until reset.
REQ-024 pc_clr or pc_up during a fetch SHALL update the PC normally without affecting the fetch in flight (fetch_addr is already latched).
REQ-025 instruction SHALL change only in the F_CAPTURE exit cycle.

Reset
REQ-026 On reset: pc_o=0, instruction=16'h0000 (NOOP), ir_valid=0, busy=0, ld_err=0, FSM=F_IDLE.
REQ-027 Reset asserted mid-fetch SHALL abort the fetch: no ir_valid pulse, and instruction is forced to 0.
REQ-028 Reset SHALL take priority over every other input in the same cycle.

Structure
REQ-029 A shared package/include (processor_pkg) SHALL hold PC_W, DATA_W, the opcode constants (NOOP=0, STORE=1, LOAD=2, ADD=3, SUBTRACT=4, HALT=5) and the fetch state encodings.
REQ-030 Instruction memory SHALL be a sub-module, inst_rom: 2^PC_W x DATA_W, synchronous read with 1-cycle latency, initialised from ROM_INIT.
REQ-031 The PC register, the fetch FSM and the instruction register SHALL reside in fetch_unit.

Verification
REQ-032 ROM preload is addr0=16'h2014, addr1=16'h1305, addr127=16'h5000. Apply reset for 2 cycles -> pc_o=0, instruction=0x0000, ir_valid=0, busy=0, ld_err=0.
REQ-033 With pc=0, pulse ld and pc_up together -> pc_o=1 next cycle; busy=1 for 2 cycles; instruction=0x2014 with ir_valid=1 in cycle N+3.
REQ-034 Set pc=127 and pulse pc_up -> pc_o=0; then pulse ld -> instruction=0x2014. From pc=127, ld without pc_up -> instruction=0x5000.
REQ-035 With pc=5, assert pc_clr and pc_up together -> pc_o=0.
REQ-036 Pulse ld at pc=1, then ld again one cycle later -> single fetch: instruction=0x1305, exactly one ir_valid pulse, ld_err=1 and held until reset.
REQ-037 Assert reset while in F_READ -> F_IDLE next cycle, instruction=0x0000, no ir_valid pulse, pc_o=0.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared processor definitions: widths, opcodes, fetch state encodings and
// the compiled-in default instruction image.
package processor_pkg;

   localparam int PC_W   = 7;
   localparam int DATA_W = 16;

   localparam logic [3:0] OP_NOOP     = 4'd0;
   localparam logic [3:0] OP_STORE    = 4'd1;
   localparam logic [3:0] OP_LOAD     = 4'd2;
   localparam logic [3:0] OP_ADD      = 4'd3;
   localparam logic [3:0] OP_SUBTRACT = 4'd4;
   localparam logic [3:0] OP_HALT     = 4'd5;

   localparam logic [1:0] F_IDLE    = 2'd0;
   localparam logic [1:0] F_READ    = 2'd1;
   localparam logic [1:0] F_CAPTURE = 2'd2;

   // Contents of inst_rom.mif, compiled in so simulation and synthesis
   // see the same image without depending on a file search path.
   function automatic logic [15:0] rom_image(input logic [31:0] addr);
      logic [15:0] word;
      word = {OP_NOOP, 12'h000};
      case (addr)
         32'd0:   word = {OP_LOAD,  12'h014};
         32'd1:   word = {OP_STORE, 12'h305};
         32'd127: word = {OP_HALT,  12'h000};
         default: word = {OP_NOOP,  12'h000};
      endcase
      return word;
   endfunction

endpackage

// File: rtl/fetch_unit_inst_rom.sv
// Instruction memory: 2^PC_W x DATA_W, synchronous read, one-cycle latency.
module inst_rom
   import processor_pkg::*;
#(
   parameter int PC_W     = processor_pkg::PC_W,
   parameter int DATA_W   = processor_pkg::DATA_W,
   parameter     ROM_INIT = "inst_rom.mif"
) (
   input  logic              clock,
   input  logic [PC_W-1:0]   addr,
   output logic [DATA_W-1:0] data
);

   // Only the default image name has a compiled-in table; any other name
   // reads as NOOP so a mistyped image never silently aliases the default.
   localparam bit USE_IMAGE = (ROM_INIT == "inst_rom.mif");

   // Registered read: data reflects addr sampled on the previous edge.
   always_ff @(posedge clock) begin
      if (USE_IMAGE)
         data <= DATA_W'(rom_image(32'(addr)));
      else
         data <= '0;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: program counter, three-state fetch FSM, instruction
// register, with the instruction memory as a sub-module.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// F_IDLE    | waiting for ld; PC only
// F_READ    | memory addressed with fetch_addr, output registered on exit
// F_CAPTURE | memory data loaded into instruction, ir_valid pulsed on exit
module fetch_unit
   import processor_pkg::*;
#(
   parameter int PC_W     = processor_pkg::PC_W,
   parameter int DATA_W   = processor_pkg::DATA_W,
   parameter     ROM_INIT = "inst_rom.mif"
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              pc_clr,
   input  logic              pc_up,
   input  logic              ld,
   output logic [DATA_W-1:0] instruction,
   output logic [PC_W-1:0]   pc_o,
   output logic              ir_valid,
   output logic              busy,
   output logic              ld_err
);

   logic [1:0]        state;
   logic [PC_W-1:0]   pc;
   logic [PC_W-1:0]   fetch_addr;
   logic [DATA_W-1:0] rom_data;

   inst_rom #(
      .PC_W     (PC_W),
      .DATA_W   (DATA_W),
      .ROM_INIT (ROM_INIT)
   ) u_rom (
      .clock (clock),
      .addr  (fetch_addr),
      .data  (rom_data)
   );

   // Program counter: clear beats increment, increment wraps naturally.
   always_ff @(posedge clock) begin
      if (reset)
         pc <= '0;
      else if (pc_clr)
         pc <= '0;
      else if (pc_up)
         pc <= pc + 1'b1;
   end

   // Fetch FSM with instruction register; fetch_addr holds the PC seen at
   // ld so PC updates during a fetch never disturb it.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= F_IDLE;
         fetch_addr  <= '0;
         instruction <= '0;
         ir_valid    <= 1'b0;
         ld_err      <= 1'b0;
      end else begin
         ir_valid <= 1'b0;
         case (state)
            F_IDLE: begin
               if (ld) begin
                  fetch_addr <= pc;
                  state      <= F_READ;
               end
            end
            F_READ: begin
               if (ld)
                  ld_err <= 1'b1;
               state <= F_CAPTURE;
            end
            F_CAPTURE: begin
               if (ld)
                  ld_err <= 1'b1;
               instruction <= rom_data;
               ir_valid    <= 1'b1;
               state       <= F_IDLE;
            end
            default: state <= F_IDLE;
         endcase
      end
   end

   // Status outputs.
   always_comb begin
      busy = (state != F_IDLE);
      pc_o = pc;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, latency, PC wrap, clear priority,
// overlapping ld and reset abort.
module tb_fetch_unit;

   logic        clock;
   logic        reset;
   logic        pc_clr;
   logic        pc_up;
   logic        ld;
   logic [15:0] instruction;
   logic [6:0]  pc_o;
   logic        ir_valid;
   logic        busy;
   logic        ld_err;

   int checks = 0;
   int errors = 0;

   fetch_unit dut (
      .clock       (clock),
      .reset       (reset),
      .pc_clr      (pc_clr),
      .pc_up       (pc_up),
      .ld          (ld),
      .instruction (instruction),
      .pc_o        (pc_o),
      .ir_valid    (ir_valid),
      .busy        (busy),
      .ld_err      (ld_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one edge; outputs settle 1 ns later.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_pc(input int value);
      pc_clr = 1'b1;
      tick();
      pc_clr = 1'b0;
      pc_up  = 1'b1;
      for (int i = 0; i < value; i++) tick();
      pc_up = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      checks++; if (pc_o !== 7'd0)          begin errors++; $display("FAIL rst_pc got %h exp 00", pc_o); end
      checks++; if (instruction !== 16'h0)  begin errors++; $display("FAIL rst_instr got %h exp 0000", instruction); end
      checks++; if (ir_valid !== 1'b0)      begin errors++; $display("FAIL rst_ir_valid got %b exp 0", ir_valid); end
      checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
      checks++; if (ld_err !== 1'b0)        begin errors++; $display("FAIL rst_ld_err got %b exp 0", ld_err); end
   endtask

   task automatic test_fetch_latency();
      ld    = 1'b1;
      pc_up = 1'b1;
      tick();
      ld    = 1'b0;
      pc_up = 1'b0;
      checks++; if (pc_o !== 7'd1)          begin errors++; $display("FAIL lat_pc got %h exp 01", pc_o); end
      checks++; if (busy !== 1'b1)          begin errors++; $display("FAIL lat_busy1 got %b exp 1", busy); end
      checks++; if (ir_valid !== 1'b0)      begin errors++; $display("FAIL lat_irv1 got %b exp 0", ir_valid); end
      tick();
      checks++; if (busy !== 1'b1)          begin errors++; $display("FAIL lat_busy2 got %b exp 1", busy); end
      checks++; if (instruction !== 16'h0)  begin errors++; $display("FAIL lat_instr_early got %h exp 0000", instruction); end
      tick();
      checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL lat_busy3 got %b exp 0", busy); end
      checks++; if (ir_valid !== 1'b1)      begin errors++; $display("FAIL lat_irv3 got %b exp 1", ir_valid); end
      checks++; if (instruction !== 16'h2014) begin errors++; $display("FAIL lat_instr got %h exp 2014", instruction); end
      tick();
      checks++; if (ir_valid !== 1'b0)      begin errors++; $display("FAIL lat_irv_pulse got %b exp 0", ir_valid); end
      checks++; if (instruction !== 16'h2014) begin errors++; $display("FAIL lat_instr_hold got %h exp 2014", instruction); end
   endtask

   task automatic test_wrap();
      set_pc(127);
      checks++; if (pc_o !== 7'd127)        begin errors++; $display("FAIL wrap_pc127 got %h exp 7f", pc_o); end
      ld = 1'b1; tick(); ld = 1'b0; tick(); tick();
      checks++; if (instruction !== 16'h5000 || ir_valid !== 1'b1)
         begin errors++; $display("FAIL wrap_fetch127 got %h/%b exp 5000/1", instruction, ir_valid); end
      pc_up = 1'b1; tick(); pc_up = 1'b0;
      checks++; if (pc_o !== 7'd0)          begin errors++; $display("FAIL wrap_pc0 got %h exp 00", pc_o); end
      ld = 1'b1; tick(); ld = 1'b0; tick(); tick();
      checks++; if (instruction !== 16'h2014 || ir_valid !== 1'b1)
         begin errors++; $display("FAIL wrap_fetch0 got %h/%b exp 2014/1", instruction, ir_valid); end
   endtask

   task automatic test_clr_priority();
      set_pc(5);
      checks++; if (pc_o !== 7'd5)          begin errors++; $display("FAIL clr_pc5 got %h exp 05", pc_o); end
      pc_clr = 1'b1; pc_up = 1'b1; tick(); pc_clr = 1'b0; pc_up = 1'b0;
      checks++; if (pc_o !== 7'd0)          begin errors++; $display("FAIL clr_prio got %h exp 00", pc_o); end
   endtask

   task automatic test_back_to_back();
      int pulses;
      set_pc(1);
      pulses = 0;
      ld = 1'b1; tick();
      tick();
      ld = 1'b0;
      if (ir_valid === 1'b1) pulses++;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (ir_valid === 1'b1) pulses++;
      end
      checks++; if (pulses != 1)            begin errors++; $display("FAIL b2b_pulses got %0d exp 1", pulses); end
      checks++; if (instruction !== 16'h1305) begin errors++; $display("FAIL b2b_instr got %h exp 1305", instruction); end
      checks++; if (ld_err !== 1'b1)        begin errors++; $display("FAIL b2b_ld_err got %b exp 1", ld_err); end
      set_pc(3);
      checks++; if (ld_err !== 1'b1)        begin errors++; $display("FAIL b2b_ld_err_sticky got %b exp 1", ld_err); end
   endtask

   task automatic test_reset_mid_fetch();
      int pulses;
      set_pc(0);
      ld = 1'b1; tick(); ld = 1'b0;
      checks++; if (busy !== 1'b1)          begin errors++; $display("FAIL abort_busy_pre got %b exp 1", busy); end
      reset = 1'b1; pc_up = 1'b1; tick(); reset = 1'b0; pc_up = 1'b0;
      checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
      checks++; if (instruction !== 16'h0)  begin errors++; $display("FAIL abort_instr got %h exp 0000", instruction); end
      checks++; if (pc_o !== 7'd0)          begin errors++; $display("FAIL abort_pc got %h exp 00", pc_o); end
      checks++; if (ld_err !== 1'b0)        begin errors++; $display("FAIL abort_ld_err got %b exp 0", ld_err); end
      pulses = (ir_valid === 1'b1) ? 1 : 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (ir_valid === 1'b1) pulses++;
      end
      checks++; if (pulses != 0)            begin errors++; $display("FAIL abort_pulses got %0d exp 0", pulses); end
      checks++; if (instruction !== 16'h0)  begin errors++; $display("FAIL abort_instr_hold got %h exp 0000", instruction); end
   endtask

   initial begin
      reset  = 1'b1;
      pc_clr = 1'b0;
      pc_up  = 1'b0;
      ld     = 1'b0;
      #2;
      test_reset();
      test_fetch_latency();
      test_wrap();
      test_clr_priority();
      test_back_to_back();
      test_reset_mid_fetch();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
